// File: rtl/seg_display_arbiter.sv
// Shares a 4-digit seven-segment display between the CPU and the debug monitor:
// round-robin req/gnt arbitration, minimum hold per value, digit scan and hex decode.
module seg_display_arbiter #(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [15:0] cpu_data,
  output logic        cpu_gnt,
  input  logic        dbg_req,
  input  logic [15:0] dbg_data,
  output logic        dbg_gnt,
  input  logic        blank_lz,
  output logic        busy,
  output logic        owner,
  output logic [7:0]  digital_light,
  output logic [3:0]  seg_en
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state;
  logic [15:0]   disp_val;
  logic          last_served;   // 0 = cpu, 1 = dbg
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] prescaler;
  logic [1:0]    digit_sel;

  logic [3:0]    nib;
  logic          blank_digit;
  logic [7:0]    light_nxt;
  logic [3:0]    en_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      disp_val    <= '0;
      cpu_gnt     <= 1'b0;
      dbg_gnt     <= 1'b0;
      busy        <= 1'b0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      hold_cnt    <= '0;
    end else begin
      cpu_gnt <= 1'b0;
      dbg_gnt <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            // CPU wins when alone, or on a tie when dbg was served last
            if (cpu_req && (!dbg_req || last_served)) begin
              disp_val    <= cpu_data;
              cpu_gnt     <= 1'b1;
              owner       <= 1'b0;
              last_served <= 1'b0;
            end else begin
              disp_val    <= dbg_data;
              dbg_gnt     <= 1'b1;
              owner       <= 1'b1;
              last_served <= 1'b1;
            end
            hold_cnt <= HOLD_INIT;
            busy     <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      digit_sel <= '0;
    end else if (prescaler == PRE_MAX) begin
      prescaler <= '0;
      digit_sel <= digit_sel + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_comb begin
    nib         = disp_val[{digit_sel, 2'b00} +: 4];
    blank_digit = 1'b0;
    if (blank_lz) begin
      case (digit_sel)
        2'd1:    blank_digit = (disp_val[15:4] == '0);
        2'd2:    blank_digit = (disp_val[15:8] == '0);
        2'd3:    blank_digit = (disp_val[15:12] == '0);
        default: blank_digit = 1'b0;
      endcase
    end
    case (nib)
      4'h0: light_nxt = 8'hFC;
      4'h1: light_nxt = 8'h60;
      4'h2: light_nxt = 8'hDA;
      4'h3: light_nxt = 8'hF2;
      4'h4: light_nxt = 8'h66;
      4'h5: light_nxt = 8'hB6;
      4'h6: light_nxt = 8'hBE;
      4'h7: light_nxt = 8'hE0;
      4'h8: light_nxt = 8'hFE;
      4'h9: light_nxt = 8'hF6;
      4'hA: light_nxt = 8'hEE;
      4'hB: light_nxt = 8'h3E;
      4'hC: light_nxt = 8'h9C;
      4'hD: light_nxt = 8'h7A;
      4'hE: light_nxt = 8'h9E;
      default: light_nxt = 8'h8E;
    endcase
    en_nxt = ~(4'b0001 << digit_sel);
    if (blank_digit) begin
      light_nxt = 8'h00;
      en_nxt    = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_en        <= 4'b1111;
      digital_light <= 8'h00;
    end else begin
      seg_en        <= en_nxt;
      digital_light <= light_nxt;
    end
  end

endmodule
